// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master.
//   spi_state_t : FSM state encoding (IDLE, SETUP, XFER, HOLD)
//   spi_mode_t  : transfer mode latched at command accept
//   cs_width    : chip-select index width, at least one bit
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  function automatic int unsigned cs_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// SCLK half-period timer.
//   clk, rst  : system clock, synchronous active-high reset
//   clr       : synchronous counter clear (command accept)
//   en        : count enable (high outside IDLE)
//   half_tick : one-cycle pulse in the last cycle of each CLK_DIV-cycle period
module spi_clk_tick #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic half_tick
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign half_tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with runtime CPOL/CPHA/bit order and one-hot chip selects.
//   clk, rst           : system clock, synchronous active-high reset
//   tx_valid/tx_ready  : command handshake, accept = tx_valid & tx_ready
//   tx_data, cs_sel    : word to send and slave index, latched at accept
//   cpol, cpha, lsb_first : transfer mode, latched at accept
//   rx_data, rx_valid  : received word and its one-cycle strobe
//   busy               : inverse of tx_ready
//   sclk, cs_n, mosi   : SPI outputs (registered); miso : SPI input
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned CLK_DIV = 50,
  parameter  int unsigned NUM_CS  = 1,
  localparam int unsigned CS_W    = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned   EW        = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_t        state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [EW-1:0]     edge_cnt;
  logic              half_tick;
  logic              accept;
  logic              leading;
  logic              last;
  logic              do_sample;
  logic              do_shift;

  function automatic logic head(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                 input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range indices match no line, so every select stays high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] d;
    d = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (32'(sel) == i) d[i] = 1'b0;
    end
    return d;
  endfunction

  assign accept = tx_valid && tx_ready;
  assign busy   = ~tx_ready;

  // Edge k = edge_cnt+1; odd k (even edge_cnt) is the leading edge.
  assign leading   = ~edge_cnt[0];
  assign last      = (edge_cnt == LAST_EDGE);
  assign do_sample = leading ? ~mode.cpha : mode.cpha;
  assign do_shift  = leading ? mode.cpha : (~mode.cpha && !last);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (state != IDLE),
    .half_tick (half_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      tx_ready <= 1'b1;
      sclk     <= 1'b0;
      cs_n     <= '1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          if (accept) begin
            state          <= SETUP;
            tx_ready       <= 1'b0;
            mode.cpol      <= cpol;
            mode.cpha      <= cpha;
            mode.lsb_first <= lsb_first;
            cs_n           <= cs_decode(cs_sel);
            edge_cnt       <= '0;
            rx_sr          <= '0;
            // cpha=0 presents the first bit during SETUP; cpha=1 waits for the leading edge.
            if (cpha) begin
              tx_sr <= tx_data;
            end else begin
              mosi  <= head(tx_data, lsb_first);
              tx_sr <= shift_out(tx_data, lsb_first);
            end
          end
        end
        SETUP: begin
          if (half_tick) state <= XFER;
        end
        XFER: begin
          if (half_tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (do_sample) rx_sr <= shift_in(rx_sr, mode.lsb_first, miso);
            if (do_shift) begin
              mosi  <= head(tx_sr, mode.lsb_first);
              tx_sr <= shift_out(tx_sr, mode.lsb_first);
            end
            if (last) state <= HOLD;
          end
        end
        HOLD: begin
          if (half_tick) begin
            state    <= IDLE;
            cs_n     <= '1;
            rx_valid <= 1'b1;
            rx_data  <= rx_sr;
            tx_ready <= 1'b1;
            mosi     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
module tb_spi_master_param;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int NCS = 5;
  localparam int LAT = (2 * DW + 2) * DIV;

  logic           clk;
  logic           rst;
  logic           tx_valid;
  logic           tx_ready;
  logic [DW-1:0]  tx_data;
  logic [2:0]     cs_sel;
  logic           cpol;
  logic           cpha;
  logic           lsb_first;
  logic [DW-1:0]  rx_data;
  logic           rx_valid;
  logic           busy;
  logic           sclk;
  logic [NCS-1:0] cs_n;
  logic           mosi;
  logic           miso;

  logic           loop_mode;
  logic           model_bit;
  logic [DW-1:0]  model_word;
  logic           m_lsb;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rx_count = 0;
  int edge_n   = 0;

  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  int            rx_times[$];
  logic          rise_q[$];
  logic [6:0]    trace_q[$];
  logic [6:0]    ref_q[$];

  assign miso = loop_mode ? mosi : model_bit;

  spi_master_param #(.DATA_W(DW), .CLK_DIV(DIV), .NUM_CS(NCS)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .cs_sel    (cs_sel),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept monitor: records the cycle number of every accepted command.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) acc_q.delete();
      else if (tx_valid && tx_ready) acc_q.push_back(cyc);
      cyc++;
    end
  end

  // Output monitor, slave model and scoreboard checker.
  initial begin
    logic prev_sclk;
    logic prev_busy;
    int   idx;
    logic [DW-1:0] e;
    int   a;
    prev_sclk = 1'b0;
    prev_busy = 1'b0;
    idx       = 0;
    model_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_count++;
        rx_times.push_back(cyc);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_rx", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e));
          // cyc has advanced one past the accept edge's own count.
          check("rx_latency", 32'(cyc - a), 32'(LAT + 1));
        end
      end
      if (busy && !prev_busy) begin
        rise_q.delete();
        trace_q.delete();
        edge_n = 0;
        idx    = 0;
      end
      if (!busy) edge_n = 0;
      if (busy) begin
        trace_q.push_back({sclk, mosi, cs_n});
        if (sclk != prev_sclk) begin
          edge_n++;
          if (edge_n % 2 == 1 && idx < DW) begin
            model_bit = m_lsb ? model_word[idx] : model_word[DW-1-idx];
            idx++;
          end
          if (sclk) rise_q.push_back(mosi);
        end
      end
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [2:0] sel, input logic pol,
                      input logic pha, input logic lsb, input logic push, input logic [DW-1:0] erx);
    int g;
    tx_data   = d;
    cs_sel    = sel;
    cpol      = pol;
    cpha      = pha;
    lsb_first = lsb;
    tx_valid  = 1'b1;
    if (push) exp_q.push_back(erx);
    g = 0;
    while (!tx_ready && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int g;
    g = 0;
    while (rx_count < target && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    check("rx_count", 32'(rx_count), 32'(target));
  endtask

  function automatic logic [DW-1:0] rise_word();
    logic [DW-1:0] v;
    v = '0;
    foreach (rise_q[i]) v = {v[DW-2:0], rise_q[i]};
    return v;
  endfunction

  initial begin
    int g;
    int diffs;
    rst        = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    cs_sel     = '0;
    cpol       = 1'b0;
    cpha       = 1'b0;
    lsb_first  = 1'b0;
    loop_mode  = 1'b1;
    model_word = '0;
    m_lsb      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_sclk",     32'(sclk),     32'd0);
    check("rst_cs_n",     32'(cs_n),     32'h1F);
    check("rst_mosi",     32'(mosi),     32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: mode 0, MSB first, loopback
    send(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    wait_rx(1);
    check("t1_rise_cnt",  32'(rise_q.size()), 32'd8);
    check("t1_mosi_bits", 32'(rise_word()),   32'hA5);

    // 2: mode 3, LSB first, slave model returns 0xC3
    loop_mode  = 1'b0;
    model_word = 8'hC3;
    m_lsb      = 1'b1;
    cpol       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t2_idle_sclk", 32'(sclk), 32'd1);
    send(8'h3C, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3);
    wait_rx(2);
    check("t2_rise_cnt",  32'(rise_q.size()), 32'd8);
    check("t2_mosi_bits", 32'(rise_word()),   32'h3C);
    check("t2_idle_sclk_after", 32'(sclk), 32'd1);
    loop_mode = 1'b1;
    cpol      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 3: chip-select decode, in range then out of range
    send(8'h5A, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    repeat (10) @(posedge clk);
    #1;
    check("t3_cs_sel2", 32'(cs_n), 32'h1B);
    wait_rx(3);
    send(8'h96, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96);
    repeat (10) @(posedge clk);
    #1;
    check("t3_cs_sel5", 32'(cs_n), 32'h1F);
    check("t3_busy",    32'(busy), 32'd1);
    wait_rx(4);

    // 4: back-to-back with tx_valid held high
    rx_times.delete();
    tx_data   = 8'h11;
    cs_sel    = 3'd0;
    cpol      = 1'b0;
    cpha      = 1'b0;
    lsb_first = 1'b0;
    tx_valid  = 1'b1;
    exp_q.push_back(8'h11);
    @(posedge clk); #1;
    tx_data = 8'h22;
    exp_q.push_back(8'h22);
    g = 0;
    while (!rx_valid && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    check("t4_rx_valid_seen", 32'(rx_valid), 32'd1);
    check("t4_cs_gap",        32'(cs_n),     32'h1F);
    check("t4_ready_in_rx",   32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("t4_cs_relow", 32'(cs_n), 32'h1E);
    check("t4_busy2",    32'(busy), 32'd1);
    wait_rx(6);
    check("t4_rx_pulses", 32'(rx_times.size()), 32'd2);
    if (rx_times.size() == 2) check("t4_gap", 32'(rx_times[1] - rx_times[0]), 32'd73);

    // 5: reset at the fifth SCLK edge aborts the transfer
    send(8'hF0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    g = 0;
    while (edge_n < 5 && g < 1000) begin
      @(negedge clk); #1;
      g++;
    end
    check("t5_edge5", 32'(edge_n), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_cs_n",     32'(cs_n),     32'h1F);
    check("t5_sclk",     32'(sclk),     32'd0);
    check("t5_mosi",     32'(mosi),     32'd0);
    check("t5_tx_ready", 32'(tx_ready), 32'd1);
    repeat (100) @(posedge clk);
    #1;
    check("t5_no_rx", 32'(rx_count), 32'd6);

    // 6: mode pins toggled mid-transfer must not change anything
    send(8'h6B, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6B);
    wait_rx(7);
    ref_q = trace_q;
    check("t6_ref_len", 32'(ref_q.size()), 32'(LAT));
    send(8'h6B, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6B);
    repeat (20) @(posedge clk);
    #1;
    cpol = 1'b1;
    cpha = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    cpha = 1'b1;
    lsb_first = 1'b1;
    wait_rx(8);
    cpol = 1'b0;
    lsb_first = 1'b0;
    diffs = 0;
    if (trace_q.size() != ref_q.size()) diffs = 1;
    else foreach (ref_q[i]) if (trace_q[i] !== ref_q[i]) diffs++;
    check("t6_trace_diffs", 32'(diffs), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("end_idle_ready", 32'(tx_ready), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
